// File: rtl/uart_pkg.sv
// Shared definitions for the uart_core TX/RX state machines and oversampling.
// Optional parity is enabled by the UART_PARITY_EN macro in uart_core.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam int OVS  = 16;
  localparam int HALF = 8;

  localparam logic [3:0] SUB_LAST  = 4'(OVS - 1);
  localparam logic [3:0] HALF_LAST = 4'(HALF - 1);

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word fall-through FIFO with full/empty flags.
// A write on a full FIFO is accepted only when a read frees a slot in the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_rd;
  logic          w_do_wr;

  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);

  // Gate the head so the output is a defined 0 while empty.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: 16x tick generator, TX/RX FSMs, TX/RX FIFOs, sticky errors.
// Define UART_PARITY_EN to build the parity bit and the PODD parameter.
module uart_core
  import uart_pkg::*;
#(
  parameter int DIV     = 651,
  parameter int DW      = 8,
  parameter int STOP2   = 0,
  parameter int FIFO_AW = 4
`ifdef UART_PARITY_EN
  ,
  parameter bit PODD    = 1'b0
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_wr,
  output logic          tx_full,
  output logic          tx_busy,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_rd,
  input  logic          err_clr,
  output logic          rx_ovr,
  output logic          rx_ferr,
  output logic          rx_perr,
  input  logic          RXD,
  output logic          TXD
);

  localparam int             TCW         = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TCW-1:0] TICK_LAST   = TCW'(DIV - 1);
  localparam logic [4:0]     TX_SUB_LAST = 5'(OVS - 1);
  localparam logic [4:0]     STOP_LAST   = 5'(OVS * ((STOP2 != 0) ? 2 : 1) - 1);
  localparam logic [3:0]     BIT_LAST    = 4'(DW - 1);

  // ---------------- oversample tick generator ----------------
  logic [TCW-1:0] r_tick_cnt;
  logic           w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RST || w_tick) r_tick_cnt <= '0;
    else               r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // ---------------- transmitter ----------------
  logic          w_txf_full;
  logic          w_txf_empty;
  logic [DW-1:0] w_txf_data;
  logic          w_tx_pop;

  uart_fifo #(.W(DW), .AW(FIFO_AW)) u_tx_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_wr    (tx_wr),
    .i_wdata (tx_data),
    .i_rd    (w_tx_pop),
    .o_rdata (w_txf_data),
    .o_full  (w_txf_full),
    .o_empty (w_txf_empty)
  );

  uart_state_e   r_tx_state;
  logic [4:0]    r_tx_sub;
  logic [3:0]    r_tx_bit;
  logic [DW-1:0] r_tx_shift;
  logic          r_txd;
`ifdef UART_PARITY_EN
  logic          r_tx_par;
`endif

  // Pop from IDLE, or straight out of the last stop tick so frames abut.
  assign w_tx_pop = w_tick && !w_txf_empty &&
                    ((r_tx_state == ST_IDLE) ||
                     ((r_tx_state == ST_STOP) && (r_tx_sub == STOP_LAST)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_state <= ST_IDLE;
      r_tx_sub   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else if (w_tick) begin
      case (r_tx_state)
        ST_IDLE: ;
        ST_START: begin
          if (r_tx_sub == TX_SUB_LAST) begin
            r_tx_sub   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= ST_DATA;
            r_txd      <= r_tx_shift[0];
          end else begin
            r_tx_sub <= r_tx_sub + 5'd1;
          end
        end
        ST_DATA: begin
          if (r_tx_sub == TX_SUB_LAST) begin
            r_tx_sub <= '0;
            if (r_tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              r_tx_state <= ST_PAR;
              r_txd      <= r_tx_par;
`else
              r_tx_state <= ST_STOP;
              r_txd      <= 1'b1;
`endif
            end else begin
              r_tx_bit   <= r_tx_bit + 4'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_sub <= r_tx_sub + 5'd1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PAR: begin
          if (r_tx_sub == TX_SUB_LAST) begin
            r_tx_sub   <= '0;
            r_tx_state <= ST_STOP;
            r_txd      <= 1'b1;
          end else begin
            r_tx_sub <= r_tx_sub + 5'd1;
          end
        end
`endif
        ST_STOP: begin
          if (r_tx_sub == STOP_LAST) begin
            r_tx_sub   <= '0;
            r_tx_state <= ST_IDLE;
          end else begin
            r_tx_sub <= r_tx_sub + 5'd1;
          end
        end
        default: begin
          r_tx_state <= ST_IDLE;
          r_txd      <= 1'b1;
        end
      endcase

      // A pop overrides the case above: load the word and begin the start bit.
      if (w_tx_pop) begin
        r_tx_state <= ST_START;
        r_tx_sub   <= '0;
        r_tx_shift <= w_txf_data;
        r_txd      <= 1'b0;
`ifdef UART_PARITY_EN
        r_tx_par   <= (^w_txf_data) ^ PODD;
`endif
      end
    end
  end

  assign TXD     = r_txd;
  assign tx_full = w_txf_full;
  assign tx_busy = !w_txf_empty || (r_tx_state != ST_IDLE);

  // ---------------- receiver ----------------
  logic          r_rxd_meta;
  logic          r_rxd_sync;
  uart_state_e   r_rx_state;
  logic [3:0]    r_rx_sub;
  logic [3:0]    r_rx_bit;
  logic [DW-1:0] r_rx_shift;
  logic          r_rx_hold;
`ifdef UART_PARITY_EN
  logic          r_rx_par;
`endif

  logic w_rxf_full;
  logic w_rxf_empty;
  logic w_stop_sample;
  logic w_rx_push;
  logic w_set_ovr;
  logic w_set_ferr;
  logic w_set_perr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= RXD;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  assign w_stop_sample = (r_rx_state == ST_STOP) && !r_rx_hold &&
                         w_tick && (r_rx_sub == SUB_LAST);
  assign w_rx_push     = w_stop_sample && r_rxd_sync && !w_rxf_full;
  assign w_set_ovr     = w_stop_sample && r_rxd_sync && w_rxf_full;
  assign w_set_ferr    = w_stop_sample && !r_rxd_sync;
`ifdef UART_PARITY_EN
  assign w_set_perr    = w_stop_sample && r_rxd_sync &&
                         ((^r_rx_shift) ^ r_rx_par ^ PODD);
`else
  assign w_set_perr    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_state <= ST_IDLE;
      r_rx_sub   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_hold  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
`endif
    end else begin
      case (r_rx_state)
        ST_IDLE: begin
          if (!r_rxd_sync) begin
            r_rx_state <= ST_START;
            r_rx_sub   <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_rx_sub == HALF_LAST) begin
              r_rx_sub   <= '0;
              r_rx_bit   <= '0;
              r_rx_state <= r_rxd_sync ? ST_IDLE : ST_DATA;
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_rx_sub == SUB_LAST) begin
              r_rx_sub   <= '0;
              r_rx_shift <= {r_rxd_sync, r_rx_shift[DW-1:1]};
              if (r_rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                r_rx_state <= ST_PAR;
`else
                r_rx_state <= ST_STOP;
`endif
              end else begin
                r_rx_bit <= r_rx_bit + 4'd1;
              end
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PAR: begin
          if (w_tick) begin
            if (r_rx_sub == SUB_LAST) begin
              r_rx_sub   <= '0;
              r_rx_par   <= r_rxd_sync;
              r_rx_state <= ST_STOP;
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          // After a framing error, hold here until the line returns high.
          if (r_rx_hold) begin
            if (r_rxd_sync) begin
              r_rx_hold  <= 1'b0;
              r_rx_state <= ST_IDLE;
            end
          end else if (w_tick) begin
            if (r_rx_sub == SUB_LAST) begin
              r_rx_sub <= '0;
              if (r_rxd_sync) r_rx_state <= ST_IDLE;
              else            r_rx_hold  <= 1'b1;
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  uart_fifo #(.W(DW), .AW(FIFO_AW)) u_rx_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_wr    (w_rx_push),
    .i_wdata (r_rx_shift),
    .i_rd    (rx_rd),
    .o_rdata (rx_data),
    .o_full  (w_rxf_full),
    .o_empty (w_rxf_empty)
  );

  assign rx_valid = !w_rxf_empty;

  // ---------------- sticky error flags ----------------
  logic r_ovr;
  logic r_ferr;
  logic r_perr;

  // Set events are written after the clear so they win in a shared cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (err_clr) begin
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
        r_perr <= 1'b0;
      end
      if (w_set_ovr)  r_ovr  <= 1'b1;
      if (w_set_ferr) r_ferr <= 1'b1;
      if (w_set_perr) r_perr <= 1'b1;
    end
  end

  assign rx_ovr  = r_ovr;
  assign rx_ferr = r_ferr;
  assign rx_perr = r_perr;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core (DIV=4: one bit = 64 clocks).
// Builds with or without UART_PARITY_EN; the parity section follows the macro.
module tb_uart_core;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
`ifdef UART_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_wr = 1'b0;
  logic          tx_full;
  logic          tx_busy;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_rd = 1'b0;
  logic          err_clr = 1'b0;
  logic          rx_ovr;
  logic          rx_ferr;
  logic          rx_perr;
  logic          RXD;
  logic          TXD;

  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  assign RXD = loop_en ? TXD : rxd_drv;

  always #5 CLK = ~CLK;

  uart_core #(
    .DIV     (DIV),
    .DW      (DW),
    .STOP2   (0),
    .FIFO_AW (4)
`ifdef UART_PARITY_EN
    ,
    .PODD    (1'b0)
`endif
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_rd    (rx_rd),
    .err_clr  (err_clr),
    .rx_ovr   (rx_ovr),
    .rx_ferr  (rx_ferr),
    .rx_perr  (rx_perr),
    .RXD      (RXD),
    .TXD      (TXD)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: words the receiver should hold, and the sticky flags.
  logic [DW-1:0] q_exp[$];
  bit m_ovr  = 1'b0;
  bit m_ferr = 1'b0;
  bit m_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // A frame as a list of line levels: start, data LSB first, [parity], stop.
  function automatic void frame_levels(input logic [DW-1:0] d, input logic stop_b,
                                       input logic par_ok, output logic lv[$]);
    lv = {};
    lv.push_back(1'b0);
    for (int i = 0; i < DW; i++) lv.push_back(d[i]);
    if (HAS_PAR) lv.push_back(par_ok ? (^d) : ~(^d));
    lv.push_back(stop_b);
  endfunction

  function automatic void model_rx(input logic [DW-1:0] d, input logic stop_b, input logic par_ok);
    if (!stop_b) m_ferr = 1'b1;
    else begin
      if (q_exp.size() == 16) m_ovr = 1'b1;
      else                    q_exp.push_back(d);
      if (HAS_PAR && !par_ok) m_perr = 1'b1;
    end
  endfunction

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_ok);
    logic lv[$];
    frame_levels(d, stop_b, par_ok, lv);
    model_rx(d, stop_b, par_ok);
    foreach (lv[i]) begin
      rxd_drv = lv[i];
      cycles(BIT);
    end
    rxd_drv = 1'b1;
    cycles(16);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovr"},  rx_ovr,  m_ovr);
    check({tag, "_ferr"}, rx_ferr, m_ferr);
    check({tag, "_perr"}, rx_perr, m_perr);
  endtask

  task automatic drain(input string tag);
    while (q_exp.size() > 0) begin
      logic [DW-1:0] e;
      e = q_exp.pop_front();
      check({tag, "_valid"}, rx_valid, 1'b1);
      check({tag, "_data"},  rx_data,  e);
      rx_rd = 1'b1;
      cycles(1);
      rx_rd = 1'b0;
    end
    check({tag, "_empty"}, rx_valid, 1'b0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic wait_txd_low(input string tag);
    int t = 0;
    while (TXD !== 1'b0 && t < 200) begin
      cycles(1);
      t++;
    end
    check({tag, "_start_seen"}, (t < 200), 1'b1);
  endtask

  task automatic wait_tx_idle(input string tag);
    int t = 0;
    while (tx_busy !== 1'b0 && t < 20000) begin
      cycles(1);
      t++;
    end
    check({tag, "_idle_seen"}, (t < 20000), 1'b1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lv[$];
    logic [DW-1:0] d;

    // ---- reset values ----
    cycles(4);
    check("rst_txd",      TXD,      1'b1);
    check("rst_tx_full",  tx_full,  1'b0);
    check("rst_tx_busy",  tx_busy,  1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data",  rx_data,  '0);
    check_flags("rst");
    RST = 1'b0;
    cycles(4);

    // ---- single TX frame, each level held one full bit ----
    tx_data = 8'hA5;
    tx_wr   = 1'b1;
    cycles(1);
    tx_wr   = 1'b0;
    wait_txd_low("tx1");
    frame_levels(8'hA5, 1'b1, 1'b1, lv);
    check("tx1_busy_in_frame", tx_busy, 1'b1);
    foreach (lv[k]) begin
      cycles(1);
      check($sformatf("tx1_bit%0d_early", k), TXD, lv[k]);
      cycles(61);
      check($sformatf("tx1_bit%0d_late", k), TXD, lv[k]);
      cycles(2);
    end
    cycles(4);
    check("tx1_busy_after", tx_busy, 1'b0);
    check("tx1_txd_idle",   TXD,     1'b1);

    // ---- loopback burst 0x00..0x0F ----
    loop_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_data = DW'(i);
      tx_wr   = 1'b1;
      cycles(1);
      q_exp.push_back(DW'(i));
    end
    tx_wr = 1'b0;
    wait_tx_idle("loop");
    cycles(16);
    loop_en = 1'b0;
    check_flags("loop");
    drain("loop");

    // ---- RX overflow: 17 random frames, no reads ----
    for (int i = 0; i < 17; i++) send_frame(DW'($urandom), 1'b1, 1'b1);
    check_flags("ovr");
    drain("ovr");
    clear_errors();
    check_flags("ovr_clr");

    // ---- framing error, re-arm, then a short glitch ----
    send_frame(DW'($urandom), 1'b0, 1'b1);
    check("ferr_no_push", rx_valid, 1'b0);
    check_flags("ferr");
    clear_errors();
    check_flags("ferr_clr");
    d = DW'($urandom);
    send_frame(d, 1'b1, 1'b1);
    drain("rearm");
    rxd_drv = 1'b0;
    cycles(20);
    rxd_drv = 1'b1;
    cycles(BIT * 12);
    check("glitch_no_push", rx_valid, 1'b0);
    check_flags("glitch");

`ifdef UART_PARITY_EN
    // ---- parity: wrong then right parity bit on 0x07 ----
    send_frame(8'h07, 1'b1, 1'b0);
    check_flags("perr_bad");
    drain("perr_bad");
    clear_errors();
    send_frame(8'h07, 1'b1, 1'b1);
    check_flags("perr_good");
    drain("perr_good");
`endif

    // ---- TX FIFO full boundary, then reset in the middle of a frame ----
    send_frame(DW'($urandom), 1'b1, 1'b1);
    check("pre_rst_rx_valid", rx_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'h5A;
      tx_wr   = 1'b1;
      cycles(1);
    end
    tx_wr = 1'b0;
    check("tx_full_set", tx_full, 1'b1);
    wait_txd_low("rst");
    cycles(BIT + BIT / 2);
    check("rst_mid_data_low", TXD, 1'b0);
    RST = 1'b1;
    cycles(1);
    check("rstmid_txd",      TXD,      1'b1);
    check("rstmid_tx_busy",  tx_busy,  1'b0);
    check("rstmid_tx_full",  tx_full,  1'b0);
    check("rstmid_rx_valid", rx_valid, 1'b0);
    check("rstmid_rx_data",  rx_data,  '0);
    q_exp.delete();
    RST = 1'b0;
    cycles(BIT * 12);
    check("post_rst_txd",  TXD,     1'b1);
    check("post_rst_busy", tx_busy, 1'b0);
    check_flags("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
